change_dispenser: RTL and testbench

//  Coin-return side of the vending machine. On a change request it takes the machine's
//  one-hot credit and drives the hopper solenoids: dimes first, then nickels.
//  It tracks the coin inventory per hopper and flags when it cannot pay out exact change.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/change_dispenser_pulse_timer.sv | 26 ++
 rtl/change_dispenser.sv | 148 ++++++++++++++
 tb/tb_change_dispenser.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine definitions: one-hot credit codes and dispenser state encodings.
package vend_pkg;

    localparam logic [3:0] S0  = 4'b1000;
    localparam logic [3:0] S5  = 4'b0100;
    localparam logic [3:0] S10 = 4'b0010;
    localparam logic [3:0] S15 = 4'b0001;

    typedef enum logic [2:0] {
        IDLE,
        DECIDE,
        DIME,
        NIC,
        GAP,
        DONE,
        ERR
    } state_t;

    // Credit in nickel units; anything not one-hot pays nothing.
    function automatic logic [1:0] credit_to_rem(input logic [3:0] credit);
        case (credit)
            S5:      return 2'd1;
            S10:     return 2'd2;
            S15:     return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Down-counter shared by solenoid pulse and inter-pulse gap timing.
module pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load,
    output logic         expired
);

    logic [W-1:0] cnt;

    // Loading N-1 keeps the caller in its state for exactly N cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (start)
            cnt <= load;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Coin-return controller: pays one-hot credit as dimes then nickels, tracks hopper inventory.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4,
    parameter int CNT_W     = 4,
    parameter int INIT_NIC  = 8,
    parameter int INIT_DIM  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ch,
    input  logic [3:0]       credit,
    input  logic             refill_nic,
    input  logic             refill_dim,
    output logic             nic_out,
    output logic             dim_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] nic_cnt,
    output logic [CNT_W-1:0] dim_cnt
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW      = $clog2(MAX_LEN + 1);
    localparam logic [TW-1:0]    PULSE_LOAD = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0]    GAP_LOAD   = TW'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] NIC_RST    = CNT_W'(INIT_NIC);
    localparam logic [CNT_W-1:0] DIM_RST    = CNT_W'(INIT_DIM);

    state_t        state;
    logic [1:0]    rem;
    logic          ch_d;
    logic          start;
    logic          take_dim;
    logic          take_nic;
    logic          timer_start;
    logic [TW-1:0] timer_load;
    logic          expired;

    always_comb begin
        start    = ch & ~ch_d & (state == IDLE);
        take_dim = (state == DECIDE) && (rem >= 2'd2) && (dim_cnt != '0);
        // Dime shortfall drops through to nickels for the same amount.
        take_nic = (state == DECIDE) && !take_dim && (rem != 2'd0) && (nic_cnt != '0);
        timer_start = take_dim | take_nic |
                      (((state == DIME) || (state == NIC)) && expired);
        timer_load  = (take_dim | take_nic) ? PULSE_LOAD : GAP_LOAD;
    end

    pulse_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (timer_start),
        .load    (timer_load),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= 2'd0;
            ch_d    <= 1'b0;
            nic_out <= 1'b0;
            dim_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ch_d <= ch;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rem   <= credit_to_rem(credit);
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    if (rem == 2'd0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (take_dim) begin
                        rem     <= rem - 2'd2;
                        dim_out <= 1'b1;
                        state   <= DIME;
                    end else if (take_nic) begin
                        rem     <= rem - 2'd1;
                        nic_out <= 1'b1;
                        state   <= NIC;
                    end else begin
                        err   <= 1'b1;
                        state <= ERR;
                    end
                end
                DIME, NIC: begin
                    if (expired) begin
                        dim_out <= 1'b0;
                        nic_out <= 1'b0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (expired)
                        state <= DECIDE;
                end
                DONE, ERR: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    dim_out <= 1'b0;
                    nic_out <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // A refill landing on the same cycle as a payout cancels it out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nic_cnt <= NIC_RST;
            dim_cnt <= DIM_RST;
        end else begin
            if (refill_nic && !take_nic) begin
                if (nic_cnt != CNT_MAX)
                    nic_cnt <= nic_cnt + 1'b1;
            end else if (take_nic && !refill_nic) begin
                nic_cnt <= nic_cnt - 1'b1;
            end

            if (refill_dim && !take_dim) begin
                if (dim_cnt != CNT_MAX)
                    dim_cnt <= dim_cnt + 1'b1;
            end else if (take_dim && !refill_dim) begin
                dim_cnt <= dim_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: per-cycle output traces against hand-built masks.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       ch;
    logic [3:0] credit;
    logic       refill_nic;
    logic       refill_dim;
    logic       nic_out;
    logic       dim_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] nic_cnt;
    logic [3:0] dim_cnt;

    int tests = 0;
    int fails = 0;

    logic [47:0] dim_tr, nic_tr, done_tr, busy_tr, err_tr;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .ch         (ch),
        .credit     (credit),
        .refill_nic (refill_nic),
        .refill_dim (refill_dim),
        .nic_out    (nic_out),
        .dim_out    (dim_out),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .nic_cnt    (nic_cnt),
        .dim_cnt    (dim_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] m(input int lo, input int hi);
        logic [47:0] r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    // Starts at a negedge; index i is the i-th negedge after the accept edge.
    // Credit is scrambled after accept to show it is not resampled.
    task automatic run_txn(input logic [3:0] cr, input int n, input bit hold);
        dim_tr = '0; nic_tr = '0; done_tr = '0; busy_tr = '0; err_tr = '0;
        credit = cr;
        ch = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) begin
                if (!hold) ch = 1'b0;
                credit = 4'b1000;
            end
            dim_tr[i] = dim_out; nic_tr[i] = nic_out; done_tr[i] = done;
            busy_tr[i] = busy;  err_tr[i] = err;
        end
        ch = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; ch = 1'b0; credit = 4'b1000; refill_nic = 1'b0; refill_dim = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({nic_out, dim_out, busy, done, err} !== 5'b0) begin
            fails++; $display("FAIL reset_outputs got=%b want=00000", {nic_out, dim_out, busy, done, err});
        end
        tests++;
        if (nic_cnt !== 4'd8 || dim_cnt !== 4'd8) begin
            fails++; $display("FAIL reset_counts got=%0d/%0d want=8/8", nic_cnt, dim_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fifteen;
        run_txn(4'b0001, 24, 1'b0);
        tests++;
        if (dim_tr !== m(2, 5)) begin fails++; $display("FAIL c15_dim got=%h want=%h", dim_tr, m(2, 5)); end
        tests++;
        if (nic_tr !== m(11, 14)) begin fails++; $display("FAIL c15_nic got=%h want=%h", nic_tr, m(11, 14)); end
        tests++;
        if (done_tr !== m(20, 20)) begin fails++; $display("FAIL c15_done got=%h want=%h", done_tr, m(20, 20)); end
        tests++;
        if (busy_tr !== m(1, 20)) begin fails++; $display("FAIL c15_busy got=%h want=%h", busy_tr, m(1, 20)); end
        tests++;
        if (nic_cnt !== 4'd7 || dim_cnt !== 4'd7) begin
            fails++; $display("FAIL c15_counts got=%0d/%0d want=7/7", nic_cnt, dim_cnt);
        end
    endtask

    task automatic test_ch_held;
        run_txn(4'b0001, 40, 1'b1);
        tests++;
        if (dim_tr !== m(2, 5) || nic_tr !== m(11, 14)) begin
            fails++; $display("FAIL held_pulses dim=%h nic=%h want dim=%h nic=%h", dim_tr, nic_tr, m(2, 5), m(11, 14));
        end
        tests++;
        if (done_tr !== m(20, 20)) begin fails++; $display("FAIL held_done got=%h want=%h", done_tr, m(20, 20)); end
        tests++;
        if ((dim_tr & nic_tr) !== 48'h0) begin fails++; $display("FAIL held_overlap got=%h want=0", dim_tr & nic_tr); end
        tests++;
        if (nic_cnt !== 4'd6 || dim_cnt !== 4'd6) begin
            fails++; $display("FAIL held_counts got=%0d/%0d want=6/6", nic_cnt, dim_cnt);
        end
    endtask

    task automatic test_refill_collide;
        refill_nic = 1'b1;
        @(negedge clk);
        refill_nic = 1'b0;
        tests++;
        if (nic_cnt !== 4'd7) begin fails++; $display("FAIL refill_one got=%0d want=7", nic_cnt); end
        credit = 4'b0100; ch = 1'b1;
        @(negedge clk);          // DECIDE cycle: refill lands with the payout
        ch = 1'b0; refill_nic = 1'b1;
        @(negedge clk);
        refill_nic = 1'b0;
        tests++;
        if (nic_out !== 1'b1 || nic_cnt !== 4'd7) begin
            fails++; $display("FAIL refill_collide got nic_out=%b cnt=%0d want 1/7", nic_out, nic_cnt);
        end
        repeat (14) @(negedge clk);
        tests++;
        if (nic_cnt !== 4'd7 || dim_cnt !== 4'd6) begin
            fails++; $display("FAIL collide_after got=%0d/%0d want=7/6", nic_cnt, dim_cnt);
        end
    endtask

    task automatic test_dime_short;
        for (int k = 0; k < 6; k++) run_txn(4'b0010, 14, 1'b0);
        tests++;
        if (dim_cnt !== 4'd0 || nic_cnt !== 4'd7) begin
            fails++; $display("FAIL drain_dimes got=%0d/%0d want=7/0", nic_cnt, dim_cnt);
        end
        run_txn(4'b0010, 24, 1'b0);
        tests++;
        if (dim_tr !== 48'h0 || nic_tr !== (m(2, 5) | m(11, 14))) begin
            fails++; $display("FAIL short_pulses dim=%h nic=%h want dim=0 nic=%h", dim_tr, nic_tr, m(2, 5) | m(11, 14));
        end
        tests++;
        if (done_tr !== m(20, 20) || err_tr !== 48'h0) begin
            fails++; $display("FAIL short_done done=%h err=%h want done=%h err=0", done_tr, err_tr, m(20, 20));
        end
        tests++;
        if (nic_cnt !== 4'd5) begin fails++; $display("FAIL short_count got=%0d want=5", nic_cnt); end
    endtask

    task automatic test_err;
        for (int k = 0; k < 5; k++) run_txn(4'b0100, 14, 1'b0);
        run_txn(4'b0100, 10, 1'b0);
        tests++;
        if (dim_tr !== 48'h0 || nic_tr !== 48'h0 || done_tr !== 48'h0) begin
            fails++; $display("FAIL err_quiet dim=%h nic=%h done=%h want all 0", dim_tr, nic_tr, done_tr);
        end
        tests++;
        if (err_tr !== m(2, 10) || busy_tr !== m(1, 2)) begin
            fails++; $display("FAIL err_flag err=%h busy=%h want err=%h busy=%h", err_tr, busy_tr, m(2, 10), m(1, 2));
        end
        run_txn(4'b1000, 8, 1'b0);
        tests++;
        if (done_tr !== m(2, 2) || err_tr !== 48'h0 || busy_tr !== m(1, 2)) begin
            fails++; $display("FAIL zero_credit done=%h err=%h busy=%h want %h/0/%h", done_tr, err_tr, busy_tr, m(2, 2), m(1, 2));
        end
        run_txn(4'b0011, 8, 1'b0);
        tests++;
        if (done_tr !== m(2, 2) || (dim_tr | nic_tr) !== 48'h0) begin
            fails++; $display("FAIL bad_credit done=%h pulses=%h want %h/0", done_tr, dim_tr | nic_tr, m(2, 2));
        end
    endtask

    task automatic test_saturate;
        refill_nic = 1'b1;
        repeat (15) @(negedge clk);
        tests++;
        if (nic_cnt !== 4'd15) begin fails++; $display("FAIL refill_fill got=%0d want=15", nic_cnt); end
        repeat (3) @(negedge clk);
        refill_nic = 1'b0;
        tests++;
        if (nic_cnt !== 4'd15) begin fails++; $display("FAIL refill_sat got=%0d want=15", nic_cnt); end
        refill_dim = 1'b1;
        repeat (3) @(negedge clk);
        refill_dim = 1'b0;
        tests++;
        if (dim_cnt !== 4'd3) begin fails++; $display("FAIL refill_dim got=%0d want=3", dim_cnt); end
    endtask

    task automatic test_reset_mid;
        credit = 4'b0001; ch = 1'b1;
        @(negedge clk);
        ch = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (dim_out !== 1'b1) begin fails++; $display("FAIL mid_pulse got=%b want=1", dim_out); end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (dim_out !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL async_drop dim_out=%b busy=%b want 0/0", dim_out, busy);
        end
        tests++;
        if (nic_cnt !== 4'd8 || dim_cnt !== 4'd8) begin
            fails++; $display("FAIL async_counts got=%0d/%0d want=8/8", nic_cnt, dim_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(4'b0100, 16, 1'b0);
        tests++;
        if (nic_tr !== m(2, 5) || done_tr !== m(11, 11) || nic_cnt !== 4'd7) begin
            fails++; $display("FAIL after_reset nic=%h done=%h cnt=%0d want %h/%h/7", nic_tr, done_tr, nic_cnt, m(2, 5), m(11, 11));
        end
    endtask

    initial begin
        test_reset;
        test_fifteen;
        test_ch_held;
        test_refill_collide;
        test_dime_short;
        test_err;
        test_saturate;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
